// File: rtl/aqp_spi_cmd_decoder_if.sv
// SPI byte stream, memory bus and status bundle of aqp_spi_cmd_decoder.
interface aqp_spi_cmd_decoder_if #(
    parameter int ADDR_WIDTH = 19
);
    logic                  msg_start;
    logic                  msg_end;
    logic [7:0]            rxdata;
    logic                  rxdata_valid;
    logic [7:0]            txdata;
    logic                  txdata_ack;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [7:0]            bus_wrdata;
    logic                  bus_wr;
    logic                  bus_req;
    logic                  bus_ack;
    logic [7:0]            bus_rddata;
    logic [7:0]            ctrl_reg;
    logic                  overrun;

    modport master (
        output msg_start, msg_end, rxdata, rxdata_valid, txdata_ack,
        output bus_ack, bus_rddata,
        input  txdata, bus_addr, bus_wrdata, bus_wr, bus_req,
        input  ctrl_reg, overrun
    );

    modport slave (
        input  msg_start, msg_end, rxdata, rxdata_valid, txdata_ack,
        input  bus_ack, bus_rddata,
        output txdata, bus_addr, bus_wrdata, bus_wr, bus_req,
        output ctrl_reg, overrun
    );
endinterface

// File: rtl/aqp_spi_cmd_decoder.sv
// ESP32 SPI command parser driving a single-request memory bus and ctrl_reg.
// Optional AQP_SPICMD_ECHO_EN: echo last rx byte on txdata outside READ.
module aqp_spi_cmd_decoder #(
    parameter int ADDR_WIDTH = 19
) (
    input logic                 clk,
    input logic                 reset,
    aqp_spi_cmd_decoder_if.slave sif
);
    typedef enum logic [3:0] {
        S_IDLE,
        S_CMD,
        S_CTRL,
        S_ADDR0,
        S_ADDR1,
        S_ADDR2,
        S_WRITE,
        S_READ,
        S_IGNORE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state;
    state_t                state_n;
    logic                  is_rd;
    logic [15:0]           addr_lo;
    logic [23:0]           addr_full;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] issue_addr;
    logic                  dummy;
    logic                  req_live;
    logic [7:0]            tx_buf;
    logic [7:0]            tx_idle;
    logic                  frame;
    logic                  cmd_we;
    logic                  ctrl_we;
    logic                  ovr_clr;
    logic                  ovr_set;
    logic                  a0_we;
    logic                  a1_we;
    logic                  a2_we;
    logic                  dummy_clr;
    logic                  issue;
    logic                  issue_wr;
    logic                  issue_ok;
    logic                  unused_addr_hi;

    assign frame          = sif.msg_start | sif.msg_end;
    assign addr_full      = {sif.rxdata, addr_lo};
    assign unused_addr_hi = ^addr_full;
    // A new request while one is outstanding is refused and flagged.
    assign issue_ok       = issue & ~sif.bus_req;
    assign ovr_set        = issue & sif.bus_req;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n    = state;
        cmd_we     = 1'b0;
        ctrl_we    = 1'b0;
        ovr_clr    = 1'b0;
        a0_we      = 1'b0;
        a1_we      = 1'b0;
        a2_we      = 1'b0;
        dummy_clr  = 1'b0;
        issue      = 1'b0;
        issue_wr   = 1'b0;
        issue_addr = addr;
        if (sif.msg_end) begin
            state_n = S_IDLE;
        end else if (sif.msg_start) begin
            state_n = S_CMD;
        end else begin
            unique case (state)
                S_CMD: if (sif.rxdata_valid) begin
                    cmd_we = 1'b1;
                    case (sif.rxdata)
                        8'h01:        state_n = S_CTRL;
                        8'h20, 8'h21: state_n = S_ADDR0;
                        8'h02: begin
                            ovr_clr = 1'b1;
                            state_n = S_IGNORE;
                        end
                        default:      state_n = S_IGNORE;
                    endcase
                end
                S_CTRL: if (sif.rxdata_valid) begin
                    ctrl_we = 1'b1;
                    state_n = S_IGNORE;
                end
                S_ADDR0: if (sif.rxdata_valid) begin
                    a0_we   = 1'b1;
                    state_n = S_ADDR1;
                end
                S_ADDR1: if (sif.rxdata_valid) begin
                    a1_we   = 1'b1;
                    state_n = S_ADDR2;
                end
                S_ADDR2: if (sif.rxdata_valid) begin
                    a2_we      = 1'b1;
                    issue      = is_rd;
                    issue_addr = addr_full[ADDR_WIDTH-1:0];
                    state_n    = is_rd ? S_READ : S_WRITE;
                end
                S_WRITE: if (sif.rxdata_valid) begin
                    issue    = 1'b1;
                    issue_wr = 1'b1;
                end
                // First shifted byte is the dummy; later acks prefetch the next one.
                S_READ: if (sif.txdata_ack) begin
                    if (dummy) dummy_clr = 1'b1;
                    else       issue     = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sif.bus_req    <= 1'b0;
            sif.bus_wr     <= 1'b0;
            sif.bus_addr   <= '0;
            sif.bus_wrdata <= 8'h00;
            sif.ctrl_reg   <= 8'h00;
            sif.overrun    <= 1'b0;
            is_rd          <= 1'b0;
            addr_lo        <= 16'h0000;
            addr           <= '0;
            dummy          <= 1'b0;
            req_live       <= 1'b0;
            tx_buf         <= 8'h00;
        end else begin
            if (sif.bus_req && sif.bus_ack) begin
                sif.bus_req <= 1'b0;
                req_live    <= 1'b0;
                if (req_live) begin
                    addr <= addr + ADDR_ONE;
                    if (!sif.bus_wr) tx_buf <= sif.bus_rddata;
                end
            end
            if (cmd_we)    is_rd          <= (sif.rxdata == 8'h21);
            if (ctrl_we)   sif.ctrl_reg   <= sif.rxdata;
            if (a0_we)     addr_lo[7:0]   <= sif.rxdata;
            if (a1_we)     addr_lo[15:8]  <= sif.rxdata;
            if (a2_we) begin
                addr  <= issue_addr;
                dummy <= is_rd;
            end
            if (dummy_clr) dummy       <= 1'b0;
            if (ovr_clr)   sif.overrun <= 1'b0;
            if (ovr_set)   sif.overrun <= 1'b1;
            if (issue_ok) begin
                sif.bus_req  <= 1'b1;
                sif.bus_wr   <= issue_wr;
                sif.bus_addr <= issue_addr;
                req_live     <= 1'b1;
                if (issue_wr) sif.bus_wrdata <= sif.rxdata;
            end
            // Framing detaches any in-flight request from the new message.
            if (frame) begin
                req_live <= 1'b0;
                dummy    <= 1'b0;
                tx_buf   <= 8'h00;
            end
        end
    end

`ifdef AQP_SPICMD_ECHO_EN
    logic [7:0] echo_q;

    always_ff @(posedge clk) begin
        if (reset)                 echo_q <= 8'h00;
        else if (sif.msg_start)    echo_q <= 8'h00;
        else if (sif.rxdata_valid) echo_q <= sif.rxdata;
    end

    assign tx_idle = echo_q;
`else
    assign tx_idle = 8'h00;
`endif

    assign sif.txdata = (state == S_READ && !dummy) ? tx_buf : tx_idle;

endmodule

// File: tb/tb_aqp_spi_cmd_decoder.sv
// Table vectors, hand sequences and a random message model for aqp_spi_cmd_decoder.
// A behavioural memory responder answers the bus with configurable latency.
module tb_aqp_spi_cmd_decoder;
    localparam int AW    = 19;
    localparam int MEMSZ = 1 << AW;
    localparam int AMASK = MEMSZ - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    aqp_spi_cmd_decoder_if #(.ADDR_WIDTH(AW)) sif ();

    aqp_spi_cmd_decoder #(.ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .sif   (sif)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  mem     [MEMSZ];
    logic [7:0]  ref_mem [MEMSZ];
    int unsigned wr_a [$];
    logic [7:0]  wr_d [$];
    int          n_rd;
    bit          hold;
    int          ack_lat;
    int          cnt;

    typedef struct packed {
        logic [3:0]  len;
        logic [63:0] msg;
        logic [7:0]  ctrl;
        logic [3:0]  nwr;
        logic [31:0] first_a;
        logic [7:0]  first_d;
        logic [31:0] last_a;
        logic [7:0]  last_d;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_msg();
        sif.msg_start = 1'b1;
        tick();
        sif.msg_start = 1'b0;
        tick();
    endtask

    task automatic end_msg();
        sif.msg_end = 1'b1;
        tick();
        sif.msg_end = 1'b0;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        sif.rxdata       = b;
        sif.rxdata_valid = 1'b1;
        tick();
        sif.rxdata_valid = 1'b0;
        repeat (6) tick();
    endtask

    task automatic tx_ack(output logic [7:0] got);
        got            = sif.txdata;
        sif.txdata_ack = 1'b1;
        tick();
        sif.txdata_ack = 1'b0;
        repeat (6) tick();
    endtask

    task automatic wait_idle(input string name);
        int i;
        i = 0;
        while (sif.bus_req === 1'b1 && i < 40) begin
            tick();
            i++;
        end
        check(name, 32'(sif.bus_req), 32'd0);
    endtask

    task automatic init_mem();
        for (int i = 0; i < MEMSZ; i++) begin
            mem[i]     = 8'(i ^ (i >> 8) ^ 32'h5A);
            ref_mem[i] = mem[i];
        end
    endtask

    // Memory responder: acks ack_lat cycles after seeing a request.
    initial begin
        sif.bus_ack    = 1'b0;
        sif.bus_rddata = 8'h00;
        cnt            = 0;
        forever begin
            @(posedge clk);
            #1;
            sif.bus_ack = 1'b0;
            if (sif.bus_req === 1'b1 && !hold && reset === 1'b0) begin
                if (cnt >= ack_lat) begin
                    sif.bus_ack = 1'b1;
                    cnt         = 0;
                    if (sif.bus_wr) begin
                        mem[sif.bus_addr] = sif.bus_wrdata;
                        wr_a.push_back(32'(sif.bus_addr));
                        wr_d.push_back(sif.bus_wrdata);
                    end else begin
                        sif.bus_rddata = mem[sif.bus_addr];
                        n_rd++;
                    end
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  got, b, c, d, a0, a1, a2, cur_ctrl, exp_echo, exp_b;
        int unsigned base;
        int          n, kind, rd0;
        int unsigned exp_a [$];
        logic [7:0]  exp_d [$];

        vecs[0] = '{4'd2, 64'h0000_0000_0000_A501, 8'hA5, 4'd0,
                    32'h0, 8'h00, 32'h0, 8'h00};
        vecs[1] = '{4'd6, 64'h0000_2211_0012_3420, 8'hA5, 4'd2,
                    32'h01234, 8'h11, 32'h01235, 8'h22};
        vecs[2] = '{4'd5, 64'h0000_0004_0302_017E, 8'hA5, 4'd0,
                    32'h0, 8'h00, 32'h0, 8'h00};
        vecs[3] = '{4'd3, 64'h0000_0000_0099_3C01, 8'h3C, 4'd0,
                    32'h0, 8'h00, 32'h0, 8'h00};
        vecs[4] = '{4'd6, 64'h0000_8877_FFFF_FF20, 8'h3C, 4'd2,
                    32'h7FFFF, 8'h77, 32'h00000, 8'h88};
        vecs[5] = '{4'd2, 64'h0000_0000_0000_0001, 8'h00, 4'd0,
                    32'h0, 8'h00, 32'h0, 8'h00};

        init_mem();
        hold             = 1'b0;
        ack_lat          = 2;
        n_rd             = 0;
        reset            = 1'b1;
        sif.msg_start    = 1'b0;
        sif.msg_end      = 1'b0;
        sif.rxdata       = 8'h00;
        sif.rxdata_valid = 1'b0;
        sif.txdata_ack   = 1'b0;
        repeat (3) tick();
        check("rst_txdata", 32'(sif.txdata), 32'h0);
        check("rst_bus_req", 32'(sif.bus_req), 32'h0);
        check("rst_bus_wr", 32'(sif.bus_wr), 32'h0);
        check("rst_bus_addr", 32'(sif.bus_addr), 32'h0);
        check("rst_bus_wrdata", 32'(sif.bus_wrdata), 32'h0);
        check("rst_ctrl", 32'(sif.ctrl_reg), 32'h0);
        check("rst_overrun", 32'(sif.overrun), 32'h0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            wr_a.delete();
            wr_d.delete();
            rd0 = n_rd;
            start_msg();
            for (int j = 0; j < int'(vecs[i].len); j++)
                send_byte(vecs[i].msg[j*8 +: 8]);
            wait_idle("vec_idle");
            check("vec_ctrl", 32'(sif.ctrl_reg), 32'(vecs[i].ctrl));
            check("vec_overrun", 32'(sif.overrun), 32'h0);
            check("vec_nwr", 32'(wr_a.size()), 32'(vecs[i].nwr));
            check("vec_nrd", 32'(n_rd - rd0), 32'h0);
            if (vecs[i].nwr != 0 && wr_a.size() != 0) begin
                check("vec_first_a", wr_a[0], vecs[i].first_a);
                check("vec_first_d", 32'(wr_d[0]), 32'(vecs[i].first_d));
                check("vec_last_a", wr_a[wr_a.size()-1], vecs[i].last_a);
                check("vec_last_d", 32'(wr_d[wr_d.size()-1]), 32'(vecs[i].last_d));
            end
            end_msg();
        end

        // Read with address wrap at the top of the space.
        mem[32'h7FFFF] = 8'hAB;
        mem[32'h00000] = 8'hCD;
        ack_lat = 1;
        start_msg();
        send_byte(8'h21);
        send_byte(8'hFF);
        send_byte(8'hFF);
        send_byte(8'h07);
        tx_ack(got);
        check("rd_wrap_dummy", 32'(got), 32'h00);
        tx_ack(got);
        check("rd_wrap_b1", 32'(got), 32'hAB);
        tx_ack(got);
        check("rd_wrap_b2", 32'(got), 32'hCD);
        wait_idle("rd_wrap_idle");
        end_msg();
        check("rd_wrap_outside", 32'(sif.txdata), 32'h00);

        // Write overrun while the bus withholds its ack.
        wr_a.delete();
        wr_d.delete();
        hold = 1'b1;
        start_msg();
        send_byte(8'h20);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        check("ovr_set", 32'(sif.overrun), 32'h1);
        check("ovr_held_data", 32'(sif.bus_wrdata), 32'h11);
        check("ovr_held_addr", 32'(sif.bus_addr), 32'h100);
        hold = 1'b0;
        wait_idle("ovr_idle");
        check("ovr_nwr", 32'(wr_a.size()), 32'h1);
        end_msg();
        check("ovr_sticky", 32'(sif.overrun), 32'h1);
        start_msg();
        send_byte(8'h02);
        check("ovr_clear", 32'(sif.overrun), 32'h0);
        end_msg();

        // msg_end with a request in flight: request completes.
        wr_a.delete();
        wr_d.delete();
        hold = 1'b1;
        start_msg();
        send_byte(8'h20);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h44);
        end_msg();
        check("end_inflight_held", 32'(sif.bus_req), 32'h1);
        hold = 1'b0;
        wait_idle("end_inflight_idle");
        check("end_inflight_nwr", 32'(wr_a.size()), 32'h1);
        check("end_inflight_addr", wr_a.size() != 0 ? wr_a[0] : 32'hDEAD, 32'h200);

        // Reset in the middle of a READ with a pending request and overrun.
        start_msg();
        send_byte(8'h01);
        send_byte(8'hC3);
        end_msg();
        check("pre_rst_ctrl", 32'(sif.ctrl_reg), 32'hC3);
        hold = 1'b1;
        start_msg();
        send_byte(8'h21);
        send_byte(8'h10);
        send_byte(8'h00);
        send_byte(8'h00);
        check("rd_pending", 32'(sif.bus_req), 32'h1);
        tx_ack(got);
        check("rd_pending_dummy", 32'(got), 32'h00);
        tx_ack(got);
        check("rd_late_ovr", 32'(sif.overrun), 32'h1);
        reset = 1'b1;
        tick();
        check("mid_rst_bus_req", 32'(sif.bus_req), 32'h0);
        check("mid_rst_bus_addr", 32'(sif.bus_addr), 32'h0);
        check("mid_rst_bus_wr", 32'(sif.bus_wr), 32'h0);
        check("mid_rst_wrdata", 32'(sif.bus_wrdata), 32'h0);
        check("mid_rst_ctrl", 32'(sif.ctrl_reg), 32'h0);
        check("mid_rst_overrun", 32'(sif.overrun), 32'h0);
        check("mid_rst_txdata", 32'(sif.txdata), 32'h0);
        reset = 1'b0;
        hold  = 1'b0;
        tick();
        cur_ctrl = 8'h00;

        // Simultaneous msg_start and msg_end: end wins, bytes ignored.
        sif.msg_start = 1'b1;
        sif.msg_end   = 1'b1;
        tick();
        sif.msg_start = 1'b0;
        sif.msg_end   = 1'b0;
        send_byte(8'h01);
        send_byte(8'h55);
        check("start_end_ctrl", 32'(sif.ctrl_reg), 32'(cur_ctrl));

        // Unknown command leaves txdata as idle/echo value.
`ifdef AQP_SPICMD_ECHO_EN
        exp_echo = 8'h3C;
`else
        exp_echo = 8'h00;
`endif
        start_msg();
        send_byte(8'h7E);
        send_byte(8'h5A);
        send_byte(8'h3C);
        check("echo_txdata", 32'(sif.txdata), 32'(exp_echo));
        end_msg();

        // Random messages against a message-level model.
        init_mem();
        for (int m = 0; m < 40; m++) begin
            kind    = $urandom_range(0, 3);
            ack_lat = $urandom_range(0, 3);
            wr_a.delete();
            wr_d.delete();
            exp_a.delete();
            exp_d.delete();
            rd0 = n_rd;
            a0  = 8'($urandom);
            a1  = 8'($urandom);
            a2  = 8'($urandom);
            base = ((32'(a2) << 16) | (32'(a1) << 8) | 32'(a0)) & AMASK;
            start_msg();
            case (kind)
                0: begin
                    b = 8'($urandom);
                    send_byte(8'h01);
                    send_byte(b);
                    cur_ctrl = b;
                end
                1: begin
                    n = $urandom_range(1, 4);
                    send_byte(8'h20);
                    send_byte(a0);
                    send_byte(a1);
                    send_byte(a2);
                    for (int i = 0; i < n; i++) begin
                        d = 8'($urandom);
                        send_byte(d);
                        exp_a.push_back((base + i) & AMASK);
                        exp_d.push_back(d);
                        ref_mem[(base + i) & AMASK] = d;
                    end
                end
                2: begin
                    n = $urandom_range(1, 4);
                    send_byte(8'h21);
                    send_byte(a0);
                    send_byte(a1);
                    send_byte(a2);
                    for (int j = 0; j < n; j++) begin
                        tx_ack(got);
                        exp_b = (j == 0) ? 8'h00 : ref_mem[(base + j - 1) & AMASK];
                        check("rnd_rd_byte", 32'(got), 32'(exp_b));
                    end
                end
                default: begin
                    c = 8'h40 | 8'($urandom & 32'h3F);
                    send_byte(c);
                    n = $urandom_range(1, 3);
                    for (int i = 0; i < n; i++) send_byte(8'($urandom));
                end
            endcase
            wait_idle("rnd_idle");
            check("rnd_ctrl", 32'(sif.ctrl_reg), 32'(cur_ctrl));
            check("rnd_overrun", 32'(sif.overrun), 32'h0);
            check("rnd_nwr", 32'(wr_a.size()), 32'(exp_a.size()));
            for (int i = 0; i < exp_a.size(); i++) begin
                if (i < wr_a.size()) begin
                    check("rnd_wr_addr", wr_a[i], exp_a[i]);
                    check("rnd_wr_data", 32'(wr_d[i]), 32'(exp_d[i]));
                end
            end
            check("rnd_nrd", 32'(n_rd - rd0), (kind == 2) ? 32'(n) : 32'h0);
            end_msg();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
